// File: rtl/qconv_khw_seq.sv
// Inner kernel-loop sequencer: walks kh x kw x ic_low, issues one input/kernel
// address pair per step over valid/ready, drains the MAC pipe, pulses finish.
module qconv_khw_seq #(
    parameter int AW          = 12,
    parameter int CW          = 4,
    parameter int MAC_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] kh_num,
    input  logic [CW-1:0] kw_num,
    input  logic [CW-1:0] ic_num,
    input  logic [CW-1:0] tile_w,
    input  logic [AW-1:0] in_base,
    output logic          step_valid,
    input  logic          step_ready,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] k_addr,
    output logic          step_first,
    output logic          step_last,
    output logic          busy,
    output logic          finish
);

    localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [DW-1:0] DRAIN_END = DW'(MAC_LATENCY - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] kh_num_q, kh_num_d, kw_num_q, kw_num_d, ic_num_q, ic_num_d;
    logic [CW-1:0] kh_q, kh_d, kw_q, kw_d, ic_q, ic_d;
    logic [AW-1:0] row_stride_q, row_stride_d, row_base_q, row_base_d;
    logic [AW-1:0] in_addr_q, in_addr_d, k_addr_q, k_addr_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          step_valid_q, step_valid_d, step_first_q, step_first_d;
    logic          step_last_q, step_last_d, busy_q, busy_d, finish_q, finish_d;
    logic [2*CW-1:0] stride_full;
    logic          accept;

    // Only multiply in the block: evaluated once per tile at start, not per step.
    assign stride_full = {{CW{1'b0}}, tile_w} * {{CW{1'b0}}, ic_num};
    assign accept      = step_valid_q && step_ready;

    always_comb begin
        state_d      = state_q;
        kh_num_d     = kh_num_q;
        kw_num_d     = kw_num_q;
        ic_num_d     = ic_num_q;
        kh_d         = kh_q;
        kw_d         = kw_q;
        ic_d         = ic_q;
        row_stride_d = row_stride_q;
        row_base_d   = row_base_q;
        in_addr_d    = in_addr_q;
        k_addr_d     = k_addr_q;
        drain_d      = drain_q;
        step_valid_d = step_valid_q;
        step_first_d = step_first_q;
        step_last_d  = step_last_q;
        finish_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kh_num_d     = kh_num;
                    kw_num_d     = kw_num;
                    ic_num_d     = ic_num;
                    row_stride_d = AW'(stride_full);
                    kh_d         = '0;
                    kw_d         = '0;
                    ic_d         = '0;
                    if (kh_num == '0 || kw_num == '0 || ic_num == '0) begin
                        state_d  = S_DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d      = S_ISSUE;
                        row_base_d   = in_base;
                        in_addr_d    = in_base;
                        k_addr_d     = '0;
                        step_valid_d = 1'b1;
                        step_first_d = 1'b1;
                        step_last_d  = (kh_num == ONE) && (kw_num == ONE) && (ic_num == ONE);
                    end
                end
            end
            S_ISSUE: begin
                if (accept && step_last_q) begin
                    state_d      = S_DRAIN;
                    drain_d      = '0;
                    step_valid_d = 1'b0;
                    step_first_d = 1'b0;
                    step_last_d  = 1'b0;
                end else if (accept) begin
                    k_addr_d     = k_addr_q + AW'(1);
                    step_first_d = 1'b0;
                    if (ic_q != ic_num_q - ONE) begin
                        ic_d      = ic_q + ONE;
                        in_addr_d = in_addr_q + AW'(1);
                    end else if (kw_q != kw_num_q - ONE) begin
                        ic_d      = '0;
                        kw_d      = kw_q + ONE;
                        in_addr_d = in_addr_q + AW'(1);
                    end else begin
                        // Row change: jump to the next input row instead of +1.
                        ic_d       = '0;
                        kw_d       = '0;
                        kh_d       = kh_q + ONE;
                        row_base_d = row_base_q + row_stride_q;
                        in_addr_d  = row_base_q + row_stride_q;
                    end
                    step_last_d = (kh_d == kh_num_q - ONE) && (kw_d == kw_num_q - ONE)
                                  && (ic_d == ic_num_q - ONE);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_END) begin
                    state_d  = S_DONE;
                    finish_d = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            kh_num_q     <= '0;
            kw_num_q     <= '0;
            ic_num_q     <= '0;
            kh_q         <= '0;
            kw_q         <= '0;
            ic_q         <= '0;
            row_stride_q <= '0;
            row_base_q   <= '0;
            in_addr_q    <= '0;
            k_addr_q     <= '0;
            drain_q      <= '0;
            step_valid_q <= 1'b0;
            step_first_q <= 1'b0;
            step_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            kh_num_q     <= kh_num_d;
            kw_num_q     <= kw_num_d;
            ic_num_q     <= ic_num_d;
            kh_q         <= kh_d;
            kw_q         <= kw_d;
            ic_q         <= ic_d;
            row_stride_q <= row_stride_d;
            row_base_q   <= row_base_d;
            in_addr_q    <= in_addr_d;
            k_addr_q     <= k_addr_d;
            drain_q      <= drain_d;
            step_valid_q <= step_valid_d;
            step_first_q <= step_first_d;
            step_last_q  <= step_last_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
        end
    end

    assign step_valid = step_valid_q;
    assign in_addr    = in_addr_q;
    assign k_addr     = k_addr_q;
    assign step_first = step_first_q;
    assign step_last  = step_last_q;
    assign busy       = busy_q;
    assign finish     = finish_q;

endmodule

// File: tb/tb_qconv_khw_seq.sv
// Scoreboard bench for qconv_khw_seq: a loop-nest reference model queues the
// expected steps and finish times; a negedge monitor checks what the DUT presents.
module tb_qconv_khw_seq;

    localparam int AW = 12;
    localparam int CW = 4;
    localparam int ML = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] k;
        logic          f;
        logic          l;
    } step_t;

    logic          clk, rst_n, start, step_ready;
    logic [CW-1:0] kh_num, kw_num, ic_num, tile_w;
    logic [AW-1:0] in_base;
    logic          step_valid, step_first, step_last, busy, finish;
    logic [AW-1:0] in_addr, k_addr;

    qconv_khw_seq #(.AW(AW), .CW(CW), .MAC_LATENCY(ML)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .kh_num(kh_num), .kw_num(kw_num), .ic_num(ic_num), .tile_w(tile_w),
        .in_base(in_base), .step_valid(step_valid), .step_ready(step_ready),
        .in_addr(in_addr), .k_addr(k_addr), .step_first(step_first),
        .step_last(step_last), .busy(busy), .finish(finish)
    );

    step_t exp_q[$];
    int    fin_q[$];
    int    fv_q[$];
    int    total = 0, bad = 0;
    int    cyc = 0, busy_cnt = 0, rdy_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    // Ready pattern generator: always, alternating, or random.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       step_ready = 1'b1;
            1:       step_ready = ~step_ready;
            default: step_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor
    initial begin
        bit    prev_vld, prev_stall;
        step_t held, got, e;
        prev_vld = 0;
        prev_stall = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 0;
                prev_stall = 0;
            end else begin
                got = {in_addr, k_addr, step_first, step_last};
                if (busy) busy_cnt++;
                if (!step_valid) chk("flags_without_valid", {step_first, step_last}, 0);
                if (prev_stall) begin
                    chk("stall_valid_held", step_valid, 1);
                    chk("stall_step_held", got, held);
                end
                if (step_valid && !prev_vld) begin
                    if (fv_q.size() == 0) fail_now("first_valid_unexpected");
                    else chk("first_valid_cycle", cyc, fv_q.pop_front());
                end
                if (step_valid && step_ready) begin
                    if (exp_q.size() == 0) fail_now("step_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("in_addr", got.a, e.a);
                        chk("k_addr", got.k, e.k);
                        chk("step_first", got.f, e.f);
                        chk("step_last", got.l, e.l);
                        if (e.l) fin_q.push_back(cyc + ML + 1);
                    end
                end
                if (finish) begin
                    if (fin_q.size() == 0) fail_now("finish_unexpected");
                    else chk("finish_cycle", cyc, fin_q.pop_front());
                end
                prev_vld = step_valid;
                prev_stall = step_valid && !step_ready;
                held = got;
            end
        end
    end

    task automatic do_start(input int kh, input int kw, input int ic, input int tw,
                            input int base, output int t);
        int idx, n;
        step_t s;
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        kh_num = CW'(kh);
        kw_num = CW'(kw);
        ic_num = CW'(ic);
        tile_w = CW'(tw);
        in_base = AW'(base);
        start = 1'b1;
        t = cyc;
        n = kh * kw * ic;
        if (n == 0) fin_q.push_back(t + 1);
        else begin
            fv_q.push_back(t + 1);
            idx = 0;
            for (int h = 0; h < kh; h++)
                for (int w = 0; w < kw; w++)
                    for (int c = 0; c < ic; c++) begin
                        s.a = AW'((base + h * tw * ic + w * ic + c) & 'hFFF);
                        s.k = AW'(idx & 'hFFF);
                        s.f = (idx == 0);
                        s.l = (idx == n - 1);
                        exp_q.push_back(s);
                        idx++;
                    end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0 && fin_q.size() == 0 && fv_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("run_complete", ok, 1);
        if (!ok) begin
            exp_q.delete();
            fin_q.delete();
            fv_q.delete();
        end
    endtask

    task automatic do_run(input int kh, input int kw, input int ic, input int tw, input int base);
        int t;
        do_start(kh, kw, ic, tw, base, t);
        wait_idle();
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {step_valid, step_first, step_last, busy, finish, in_addr, k_addr}, 0);
    endtask

    initial begin
        int t, b0;
        rst_n = 1'b0;
        start = 1'b0;
        step_ready = 1'b1;
        kh_num = '0;
        kw_num = '0;
        ic_num = '0;
        tile_w = '0;
        in_base = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        rst_n = 1'b1;

        // 3x3x2 tile, ready always high
        rdy_mode = 0;
        b0 = busy_cnt;
        do_start(3, 3, 2, 4, 0, t);
        wait_idle();
        chk("busy_cycles_3x3x2", busy_cnt - b0, 18 + ML + 1);

        // same config with alternating ready
        rdy_mode = 1;
        do_run(3, 3, 2, 4, 0);
        rdy_mode = 0;

        // single step at top of address space, then address wrap across rows
        do_run(1, 1, 1, 5, 'hFFF);
        do_run(2, 1, 1, 1, 'hFFF);

        // zero-size config
        b0 = busy_cnt;
        do_run(2, 2, 0, 3, 'h123);
        chk("busy_cycles_zero", busy_cnt - b0, 1);

        // reset while presenting step 7, then a fresh run
        do_start(3, 3, 2, 4, 'h100, t);
        for (int i = 0; i < 100; i++) begin
            if (step_valid && k_addr == AW'(7)) break;
            @(posedge clk);
            #1;
        end
        chk("reached_step7", k_addr, 7);
        rst_n = 1'b0;
        exp_q.delete();
        fin_q.delete();
        fv_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all_zero("after_midrun_reset");
        repeat (10) @(posedge clk);
        #1;
        do_run(2, 2, 2, 3, 'h0A0);

        // extra start pulses in ISSUE and in DONE are ignored
        do_start(3, 3, 2, 4, 'h040, t);
        repeat (5) @(posedge clk);
        #1;
        kh_num = 4'd1;
        kw_num = 4'd1;
        ic_num = 4'd1;
        in_base = 12'h777;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (finish) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_ignored_starts", busy, 0);

        // randomized configurations and ready patterns
        for (int r = 0; r < 16; r++) begin
            rdy_mode = $urandom_range(0, 2);
            do_run($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 4),
                   $urandom_range(0, 15), $urandom_range(0, 4095));
        end
        rdy_mode = 0;

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qconv_khw_seq.md
Name: qconv_khw_seq

Overview:
Sequencer for the inner kernel loop of the quantized convolution engine.
- On a start pulse from the ihw_high loop controller, walks kh × kw × ic_low.
- Issues one input-buffer address and one kernel-buffer address per step to the MAC datapath over a valid/ready handshake.
- Drains the MAC pipeline, then returns a one-cycle finish pulse. The parent latches this pulse as its KHW-done flag.

Parameters:
AW, 12, width of in_addr / k_addr / in_base
CW, 4, width of kh_num, kw_num, ic_num, tile_w
MAC_LATENCY, 4, MAC pipeline depth in cycles, waited after the last accepted step (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  reset (see Behaviour)
start  in  1  one-cycle start pulse; honoured only in IDLE
kh_num  in  CW  kernel height; sampled at start
kw_num  in  CW  kernel width; sampled at start
ic_num  in  CW  input-channel words per pixel; sampled at start
tile_w  in  CW  input tile width in pixels; sampled at start
in_base  in  AW  input-buffer base address for this tile; sampled at start
step_valid  out  1  step address valid
step_ready  in  1  datapath accepts step
in_addr  out  AW  input-buffer word address
k_addr  out  AW  kernel-buffer word address
step_first  out  1  qualifies first step (datapath clears accumulator)
step_last  out  1  qualifies final step
busy  out  1  high whenever state ≠ IDLE
finish  out  1  one-cycle completion pulse

Behaviour:
- Clock is clk. Reset is rst_n, synchronous, active-low.
- Reset, including mid-operation: state=IDLE; all counters=0; step_valid, step_first, step_last, busy and finish=0; in_addr and k_addr=0. No finish pulse is emitted for an aborted run.
- States:
  - IDLE: if start, latch config and row_stride = tile_w*ic_num (truncated to AW). If any of kh_num, kw_num, ic_num is 0, go to DONE; else go to ISSUE. Otherwise stay.
  - ISSUE: step_valid=1. Accept happens when step_valid && step_ready.
    - On accept of a non-last step, advance the counters.
    - On accept of the last step, go to DRAIN with drain_cnt=0.
  - DRAIN: drain_cnt increments each cycle. Go to DONE when drain_cnt==MAC_LATENCY-1, i.e. MAC_LATENCY cycles in DRAIN.
  - DONE: finish=1 for exactly this cycle, then IDLE.
- Loop order: ic innermost, then kw, then kh outermost.
  - ic wraps at ic_num-1 and increments kw.
  - kw wraps at kw_num-1 and increments kh.
  - The last step is kh=kh_num-1, kw=kw_num-1, ic=ic_num-1.
- Addresses are registered and computed incrementally (no multipliers in the loop), modulo 2^AW:
  - k_addr starts at 0 and increments by 1 on every accept.
  - in_addr starts at in_base. On ic or kw advance, in_addr += 1. On kh advance, row_base += row_stride and in_addr = new row_base.
  - Equivalent form: in_addr = in_base + kh*tile_w*ic_num + kw*ic_num + ic.
- step_first=1 only while presenting step 0. step_last=1 only while presenting the last step. Both are gated by step_valid.
- Stall: while step_valid && !step_ready, in_addr, k_addr, step_first and step_last are held stable. step_valid never drops before accept.
- Latency:
  - start at cycle T → first step_valid at T+1.
  - Last accept at cycle A → finish at A+MAC_LATENCY+1.
  - Zero-size config: finish at T+1, step_valid never asserted.
- start outside IDLE is ignored; config inputs are not re-sampled.
- start on the same cycle as finish (state DONE) is ignored. The parent must wait for IDLE (busy=0).
- Single-step config (1,1,1): step_first and step_last are both high on the same step.

Test Plan:
1. kh=kw=3, ic=2, tile_w=4, in_base=0, ready=1, start at T:
   - 18 accepts on T+1..T+18.
   - in_addr = 0..5, 8..13, 16..21; k_addr = 0..17.
   - step_first at T+1, step_last at T+18, finish only at T+23, busy T+1..T+23.
2. Same config with ready low on every other cycle: identical address sequence; addresses held during stalls; finish exactly 5 cycles after the 18th accept.
3. kh=1, kw=1, ic=1, in_base=0xFFF: single step, in_addr=0xFFF, step_first=step_last=1, finish at T+6. Then kh=2, tile_w=1, ic=1, in_base=0xFFF: in_addr sequence 0xFFF, 0x000 (wrap).
4. ic_num=0 with start at T: finish at T+1, step_valid never high, busy high only at T+1.
5. Reset driven low for one cycle while in ISSUE at step 7, then a fresh start: all outputs 0 the cycle after reset, no finish pulse, and the new run begins again at k_addr=0 with in_addr=in_base.
6. Second start pulse during ISSUE and another during DONE: both ignored; step count stays 18 and exactly one finish pulse is produced.
